// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read-only slave over a word memory loaded through a backdoor port.
// Requests queue in a 2-deep AR FIFO; a single burst engine streams one beat per cycle.
module axi_rd_responder #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_WIDTH-1:0]      s_axi_rid,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     bd_we,
  input  logic [$clog2(DEPTH)-1:0] bd_addr,
  input  logic [DATA_WIDTH-1:0]    bd_wdata
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WAW = ADDR_WIDTH - 3;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [WAW-1:0]      waddr;
    logic [7:0]          len;
    logic [2:0]          size;
    logic [1:0]          burst;
  } ar_t;

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ar_t                   fifo [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count, count_n;
  state_t                state;
  logic [WAW-1:0]        cur_waddr, beat_waddr;
  logic [7:0]            beats_left;
  logic                  cur_fixed, cur_slverr;

  ar_t  ar_in, req;
  logic ar_hs, need_new, next_beat, pop, bypass, push, start;
  logic beat_slverr, beat_decerr;
  logic unused_lsb;

  // Byte offset within a word never matters: every beat is a full aligned word.
  assign unused_lsb = ^s_axi_araddr[2:0];
  assign ar_in = {s_axi_arid, s_axi_araddr[ADDR_WIDTH-1:3], s_axi_arlen, s_axi_arsize, s_axi_arburst};

  always_comb begin
    ar_hs     = s_axi_arvalid && s_axi_arready;
    need_new  = (state == IDLE) || (s_axi_rvalid && s_axi_rready && s_axi_rlast);
    next_beat = s_axi_rvalid && s_axi_rready && !s_axi_rlast;
    pop       = need_new && (count != 2'd0);
    // An empty FIFO lets a fresh request skip straight to the beat register.
    bypass    = need_new && (count == 2'd0) && ar_hs;
    push      = ar_hs && !bypass;
    start     = pop || bypass;
    req       = pop ? fifo[rd_ptr] : ar_in;
    count_n   = count + {1'b0, push} - {1'b0, pop};
    if (start) begin
      beat_waddr  = req.waddr;
      beat_slverr = (req.size != 3'd3) || req.burst[1];
    end else begin
      beat_waddr  = cur_fixed ? cur_waddr : cur_waddr + 1'b1;
      beat_slverr = cur_slverr;
    end
    // Range check uses the full word address, so high address bits can't alias in.
    beat_decerr = (beat_waddr >> AW) != '0;
  end

  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      cur_waddr     <= '0;
      beats_left    <= 8'd0;
      cur_fixed     <= 1'b0;
      cur_slverr    <= 1'b0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= ar_in;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count         <= count_n;
      s_axi_arready <= (count_n != 2'd2);

      if (start || next_beat) begin
        state        <= BURST;
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= (beat_slverr || beat_decerr) ? '0 : mem[beat_waddr[AW-1:0]];
        s_axi_rresp  <= beat_slverr ? 2'b10 : (beat_decerr ? 2'b11 : 2'b00);
        cur_waddr    <= beat_waddr;
        if (start) begin
          s_axi_rid   <= req.id;
          beats_left  <= req.len;
          s_axi_rlast <= (req.len == 8'd0);
          cur_fixed   <= (req.burst == 2'b00);
          cur_slverr  <= beat_slverr;
        end else begin
          beats_left  <= beats_left - 8'd1;
          s_axi_rlast <= (beats_left == 8'd1);
        end
      end else if (s_axi_rvalid && s_axi_rready) begin
        state        <= IDLE;
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: vector table, directed corner sequences and a random
// phase, all beats scored against a queue built from the address/response rules.
module tb_axi_rd_responder;
  localparam int IDW = 13, AWD = 64, DW = 64, DEPTH = 1024, IW = $clog2(DEPTH);

  logic clk = 1'b0, reset = 1'b0;
  logic [IDW-1:0] s_axi_arid = '0;
  logic [AWD-1:0] s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = '0;
  logic [1:0]     s_axi_arburst = '0;
  logic           s_axi_arvalid = 1'b0, s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast, s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           bd_we = 1'b0;
  logic [IW-1:0]  bd_addr = '0;
  logic [DW-1:0]  bd_wdata = '0;

  always #5 clk = ~clk;

  axi_rd_responder #(.ID_WIDTH(IDW), .ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata)
  );

  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;
  typedef struct { logic [AWD-1:0] addr; logic [2:0] size; logic [1:0] burst;
                   logic [1:0] resp; logic [DW-1:0] data; } vec_t;

  beat_t         exp_q[$];
  beat_t         mon_e;
  int            acc_cyc[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            total = 0, bad = 0, cyc = 0, hs_cyc = 0;
  bit            sb_on = 0, rr_const = 0, held = 0;
  int            rr_mode = 0;
  logic [127:0]  saved;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: expand a request into its beats straight from the address/response rules.
  task automatic model_burst(input logic [IDW-1:0] id, input logic [AWD-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [AWD-1:0] w;
    beat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      w      = (addr >> 3) + ((burst == 2'b00) ? 0 : i);
      b.id   = id;
      b.last = (i == int'(len));
      if (size != 3'd3 || burst[1]) begin b.data = '0; b.resp = 2'b10; end
      else if (w >= DEPTH)          begin b.data = '0; b.resp = 2'b11; end
      else                          begin b.data = ref_mem[w[IW-1:0]]; b.resp = 2'b00; end
      exp_q.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Called just after a posedge; returns just after the handshake edge.
  task automatic do_ar(input logic [IDW-1:0] id, input logic [AWD-1:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    s_axi_arvalid = 1; s_axi_arid = id; s_axi_araddr = addr;
    s_axi_arlen = len; s_axi_arsize = size; s_axi_arburst = burst;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (s_axi_arready) begin
        done = 1; hs_cyc = cyc;
        if (sb_on) model_burst(id, addr, len, size, burst);
      end
    end
    if (!done) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 0;
  endtask

  task automatic wait_drain(input int max);
    int k = 0;
    while (exp_q.size() != 0 && k < max) begin @(posedge clk); k++; end
    if (exp_q.size() != 0) begin chk("drain_timeout", exp_q.size(), 0); exp_q.delete(); end
    @(posedge clk); #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       s_axi_rready = rr_const;
      1:       s_axi_rready = ~s_axi_rready;
      default: s_axi_rready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: every accepted beat must match the head of the expected queue,
  // and a stalled beat must not change.
  always @(negedge clk) begin
    if (sb_on && reset) begin
      if (held) begin
        chk("hold_valid", s_axi_rvalid, 1);
        chk("hold_stable", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, saved);
      end
      if (s_axi_rvalid && s_axi_rready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rid", s_axi_rid, mon_e.id);
          chk("rdata", s_axi_rdata, mon_e.data);
          chk("rresp", s_axi_rresp, mon_e.resp);
          chk("rlast", s_axi_rlast, mon_e.last);
        end
      end
      held  = s_axi_rvalid && !s_axi_rready;
      saved = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
    end else held = 0;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   nv;
    tbl[0] = '{64'h10, 3'd3, 2'b01, 2'b00, 64'h1002};
    tbl[1] = '{64'h17, 3'd3, 2'b01, 2'b00, 64'h1002};
    tbl[2] = '{64'h38, 3'd3, 2'b00, 2'b00, 64'h1007};
    tbl[3] = '{64'h08, 3'd2, 2'b01, 2'b10, 64'h0};
    tbl[4] = '{64'h08, 3'd3, 2'b10, 2'b10, 64'h0};
    tbl[5] = '{64'h08, 3'd3, 2'b11, 2'b10, 64'h0};
    tbl[6] = '{64'(DEPTH * 8), 3'd3, 2'b01, 2'b11, 64'h0};
    tbl[7] = '{64'(DEPTH * 8 - 8), 3'd3, 2'b01, 2'b00, 64'hDEAD_BEEF_0123_4567};
    tbl[8] = '{64'h100_0000_0010, 3'd3, 2'b00, 2'b11, 64'h0};
    tbl[9] = '{64'h20, 3'd1, 2'b00, 2'b10, 64'h0};

    // Reset state and arready rise
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_rlast", s_axi_rlast, 0);
    chk("rst_rid", s_axi_rid, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    @(posedge clk); #1; reset = 1;
    @(negedge clk); chk("arready_pre_edge", s_axi_arready, 0);
    @(negedge clk); chk("arready_rise", s_axi_arready, 1);

    // Preload
    @(posedge clk); #1;
    bd_we = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bd_addr  = IW'(i);
      bd_wdata = (i < 8) ? 64'h1000 + 64'(i) :
                 (i == DEPTH - 1) ? 64'hDEAD_BEEF_0123_4567 : {$urandom, $urandom};
      ref_mem[i] = bd_wdata;
      step();
    end
    bd_we = 0;

    // Single-beat vectors
    sb_on = 0; rr_mode = 0; rr_const = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      do_ar(IDW'(i + 1), tbl[i].addr, 8'd0, tbl[i].size, tbl[i].burst);
      @(negedge clk);
      chk($sformatf("tbl%0d_rvalid", i), s_axi_rvalid, 1);
      chk($sformatf("tbl%0d_rdata", i), s_axi_rdata, tbl[i].data);
      chk($sformatf("tbl%0d_rresp", i), s_axi_rresp, tbl[i].resp);
      chk($sformatf("tbl%0d_rlast", i), s_axi_rlast, 1);
      chk($sformatf("tbl%0d_rid", i), s_axi_rid, i + 1);
      rr_const = 1;
      @(posedge clk); @(negedge clk);
      rr_const = 0;
      @(posedge clk); @(negedge clk);
      chk($sformatf("tbl%0d_drop", i), s_axi_rvalid, 0);
      step();
    end

    // 8-beat INCR at full rate
    sb_on = 1; rr_const = 1; step(); step();
    acc_cyc.delete();
    do_ar(IDW'(5), 64'h0, 8'd7, 3'd3, 2'b01);
    wait_drain(100);
    chk("b8_beats", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8) begin
      chk("b8_first_lat", acc_cyc[0], hs_cyc + 1);
      chk("b8_span", acc_cyc[7] - acc_cyc[0], 7);
    end

    // Same burst with rready toggling
    rr_mode = 1; acc_cyc.delete();
    do_ar(IDW'(5), 64'h0, 8'd7, 3'd3, 2'b01);
    wait_drain(100);
    chk("tog_beats", acc_cyc.size(), 8);
    if (acc_cyc.size() == 8)
      for (int i = 1; i < 8; i++) chk("tog_gap", acc_cyc[i] - acc_cyc[i - 1], 2);

    // FIFO fill, stall, then gapless drain
    rr_mode = 0; rr_const = 0; step(); step();
    acc_cyc.delete();
    do_ar(IDW'(1), 64'h40, 8'd1, 3'd3, 2'b01);
    do_ar(IDW'(2), 64'h80, 8'd1, 3'd3, 2'b01);
    do_ar(IDW'(3), 64'hC0, 8'd1, 3'd3, 2'b01);
    @(negedge clk); chk("fifo_full", s_axi_arready, 0);
    step(); step();
    @(negedge clk); chk("fifo_stall", s_axi_arready, 0);
    step();
    rr_const = 1;
    wait_drain(100);
    chk("fifo_beats", acc_cyc.size(), 6);
    if (acc_cyc.size() == 6)
      for (int i = 1; i < 6; i++) chk("fifo_gap", acc_cyc[i] - acc_cyc[i - 1], 1);

    // Range edge, illegal bursts, FIXED
    do_ar(IDW'(7), 64'(DEPTH * 8 - 16), 8'd3, 3'd3, 2'b01);
    do_ar(IDW'(8), 64'h100, 8'd2, 3'd3, 2'b10);
    do_ar(IDW'(9), 64'h100, 8'd2, 3'd2, 2'b01);
    do_ar(IDW'(10), 64'h18, 8'd3, 3'd3, 2'b00);
    wait_drain(200);

    // Backdoor write in the same cycle as the fetch returns old data
    s_axi_arvalid = 1; s_axi_arid = IDW'(11); s_axi_araddr = 64'(30 * 8);
    s_axi_arlen = 8'd0; s_axi_arsize = 3'd3; s_axi_arburst = 2'b01;
    bd_we = 1; bd_addr = IW'(30); bd_wdata = 64'hA5A5_0000_1111_2222;
    @(negedge clk);
    chk("bd_ar_ready", s_axi_arready, 1);
    model_burst(IDW'(11), 64'(30 * 8), 8'd0, 3'd3, 2'b01);
    @(posedge clk); #1;
    s_axi_arvalid = 0; bd_we = 0; ref_mem[30] = 64'hA5A5_0000_1111_2222;
    wait_drain(50);

    // Backdoor write under a stalled beat leaves the beat intact
    rr_const = 0; step(); step();
    do_ar(IDW'(12), 64'(31 * 8), 8'd0, 3'd3, 2'b01);
    bd_we = 1; bd_addr = IW'(31); bd_wdata = 64'h5A5A_3333_4444_5555;
    step();
    bd_we = 0; ref_mem[31] = 64'h5A5A_3333_4444_5555;
    step();
    rr_const = 1;
    wait_drain(50);
    do_ar(IDW'(13), 64'(30 * 8), 8'd1, 3'd3, 2'b01);
    wait_drain(50);

    // Reset mid-burst
    acc_cyc.delete();
    do_ar(IDW'(9), 64'h0, 8'd7, 3'd3, 2'b01);
    for (int k = 0; k < 50 && acc_cyc.size() < 3; k++) @(posedge clk);
    chk("mid_three", acc_cyc.size() >= 3, 1);
    #1; reset = 0; sb_on = 0;
    @(posedge clk); @(negedge clk);
    chk("mid_rvalid_off", s_axi_rvalid, 0);
    chk("mid_arready_off", s_axi_arready, 0);
    exp_q.delete();
    step(); reset = 1;
    nv = 0;
    repeat (10) begin @(negedge clk); if (s_axi_rvalid) nv++; end
    chk("mid_no_beats", nv, 0);
    chk("mid_arready", s_axi_arready, 1);
    step();
    sb_on = 1; acc_cyc.delete();
    do_ar(IDW'(4), 64'h0, 8'd7, 3'd3, 2'b01);
    wait_drain(100);
    chk("mid_new_beats", acc_cyc.size(), 8);

    // Random traffic with random backpressure
    rr_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [AWD-1:0] a;
      logic [7:0]     l;
      logic [2:0]     s;
      logic [1:0]     b;
      int             sel;
      sel = $urandom_range(0, 9);
      s = 3'd3;
      b = 2'($urandom_range(0, 1));
      if (sel < 6)       a = 64'($urandom_range(0, DEPTH * 8 - 1));
      else if (sel < 8)  a = 64'(DEPTH * 8 - 8 * $urandom_range(1, 4) + $urandom_range(0, 7));
      else if (sel == 8) a = {4'h0, 28'($urandom), $urandom} | 64'h1_0000_0000;
      else begin
        a = 64'($urandom_range(0, 255));
        s = 3'($urandom_range(0, 7));
        b = 2'($urandom_range(0, 3));
        if (s == 3'd3 && !b[1]) b = 2'b10;
      end
      l = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      do_ar(IDW'($urandom), a, l, s, b);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_drain(20000);
    rr_mode = 0; rr_const = 1;
    repeat (5) step();
    @(negedge clk);
    chk("final_idle", s_axi_rvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_rd_responder.md
AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, 13, AXI ID width; ADDR_WIDTH, 64, byte address width; DATA_WIDTH, 64, data beat width; DEPTH, 1024, memory size in 64-bit words (power of 2).
REQ-002 clk  in  1  clock; all state SHALL change on posedge only.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 s_axi_arid  in  ID_WIDTH  read request ID.
REQ-005 s_axi_araddr  in  ADDR_WIDTH  burst start byte address.
REQ-006 s_axi_arlen  in  8  number of beats minus 1.
REQ-007 s_axi_arsize  in  3  beat size (log2 bytes).
REQ-008 s_axi_arburst  in  2  burst type.
REQ-009 s_axi_arvalid  in  1  request valid.
REQ-010 s_axi_arready  out  1  request accepted when high with arvalid.
REQ-011 s_axi_rid  out  ID_WIDTH  echoed request ID.
REQ-012 s_axi_rdata  out  DATA_WIDTH  beat data.
REQ-013 s_axi_rresp  out  2  beat response.
REQ-014 s_axi_rlast  out  1  final beat of burst.
REQ-015 s_axi_rvalid  out  1  beat valid.
REQ-016 s_axi_rready  in  1  master accepts beat.
REQ-017 bd_we  in  1  backdoor word write enable.
REQ-018 bd_addr  in  log2(DEPTH)  backdoor word index.
REQ-019 bd_wdata  in  DATA_WIDTH  backdoor write data.

Function
REQ-020 AR requests SHALL enter a 2-entry FIFO that holds {id, addr, len, size, burst}; arready = FIFO not full (registered, no combinational path from arvalid).
REQ-021 The FSM SHALL have states IDLE and BURST; IDLE->BURST when the FIFO is non-empty (pop entry, load beat counter = len, load word pointer = addr[log2(DEPTH)+2:3]); BURST->IDLE on an accepted beat (rvalid&rready) with rlast=1 and an empty FIFO; BURST->BURST (pop next entry) on an accepted last beat with a non-empty FIFO, with no idle bubble.
REQ-022 The first beat SHALL assert rvalid exactly 1 cycle after the AR handshake cycle when the block is in IDLE with an empty FIFO.
REQ-023 Once rvalid is asserted, rid/rdata/rresp/rlast SHALL stay stable until rready; no beat SHALL be dropped or duplicated.
REQ-024 Beats SHALL advance one per cycle while rready=1 (full throughput); rlast=1 only on beat index len.
REQ-025 Word pointer: INCR (2'b01) +1 per beat; FIXED (2'b00) constant.
REQ-026 rresp = 2'b10 (SLVERR), rdata = 0 for all beats if arsize != 3 or arburst in {2'b10, 2'b11}; the burst SHALL still deliver len+1 beats.
REQ-027 rresp = 2'b11 (DECERR), rdata = 0 for any beat whose byte address >= DEPTH*8 (checked per beat, addr upper bits included); in-range beats of the same burst return OKAY (2'b00).
REQ-028 Byte-address low bits [2:0] SHALL be ignored (aligned to word).
REQ-029 A backdoor write SHALL take effect at the posedge; a beat already presented (rvalid=1) SHALL keep its data; a beat fetched in the same cycle as a write to its word SHALL return the old data.
REQ-030 AR handshake and FIFO pop in the same cycle SHALL both occur; occupancy stays unchanged.
REQ-031 arlen=0 SHALL produce a single beat with rlast=1.

Reset
REQ-032 When reset=0 at posedge: FIFO empty, FSM IDLE, arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0; arready SHALL rise on the first posedge after reset=1.
REQ-033 Reset mid-burst SHALL abandon the burst and flush the FIFO; memory contents SHALL be preserved.

Verification
REQ-034 Preload words 0..7 = 0x1000+i; AR addr=0, len=7, INCR, size=3, id=0x5, rready=1 -> 8 beats on consecutive cycles, first beat 1 cycle after AR, data 0x1000..0x1007, rid=0x5, rlast only on the 8th, rresp=0.
REQ-035 Same burst with rready toggling 1/0 every cycle -> identical data sequence, outputs stable while stalled, 15 cycles total from first to last beat.
REQ-036 Three back-to-back ARs (len=1, ids 1,2,3) with rready=0 -> third AR stalls (arready=0) after FIFO fills; on release, 6 beats with no gaps, ids in order 1,1,2,2,3,3.
REQ-037 AR addr=DEPTH*8-16, len=3, INCR -> beats 0-1 OKAY with memory data, beats 2-3 DECERR with rdata=0.
REQ-038 AR arburst=2'b10, len=2 -> 3 beats SLVERR, rdata=0; AR arsize=2 -> same result.
REQ-039 Reset asserted after beat 3 of an 8-beat burst -> rvalid=0 next cycle, no further beats after release; a new AR returns preloaded data unchanged.
